operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Decode/operand stage directly upstream of the ALU. Holds the 32x32 MIPS register file.
//  Reads rs/rt for the incoming instruction and builds the immediate operand.
//  Latches ALU operands a/b, store data and destination register into an ID/EX output register.
//  Write-back from the downstream stage enters here and is bypassed to same-cycle reads.
// PARAMETERS
//  DW      32  datapath width (register, operand and immediate-extension width)
//  NREGS   32  register count; the address width is log2(NREGS) = 5
// PORTS
//  clk        in   1   clock, all state updates on the rising edge
//  rst        in   1   reset, synchronous, active-high
//  instr      in   32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
//  instr_vld  in   1   instr is valid this cycle
//  stall      in   1   hold the output register, do not accept instr
//  flush      in   1   squash the output register (branch redirect)
//  wb_we      in   1   register write enable
//  wb_addr    in   5   register write address
//  wb_data    in   32  register write data
//  op_a       out  32  ALU operand a = R[rs]
//  op_b       out  32  ALU operand b = R[rt] or extended immediate
//  st_data    out  32  R[rt], store data for sw
//  dest       out  5   destination register: rd for R-type, rt otherwise
//  out_vld    out  1   output register holds a live instruction
// BEHAVIOUR
//  Reset:
//   - While rst=1 at an edge, all registers R[0..31] are cleared to 0.
//   - op_a, op_b, st_data, dest and out_vld are all cleared to 0.
//   - wb_we is ignored during reset.
//   - Reset mid-stream discards any in-flight instruction.
//  Register file:
//   - Write occurs at the clock edge when wb_we=1 and wb_addr!=0.
//   - R[0] always reads 0; writes to it are dropped.
//  Read and bypass:
//   - Reads are combinational from rs and rt.
//   - If wb_we=1, wb_addr!=0 and wb_addr equals rs (or rt), the read returns wb_data (same-cycle bypass).
//  Decode (combinational, ahead of the output register):
//   - Opcode 0x00 (R-type), 0x04 (beq), 0x05 (bne): op_b = R[rt].
//   - All other opcodes: op_b = extended imm.
//   - Opcode 0x0C (andi) and 0x0D (ori): imm is zero-extended.
//   - All other opcodes: imm is sign-extended from bit 15.
//   - dest = rd when opcode==0, else rt.
//  Output register, 1-cycle latency, priority rst > flush > stall > load:
//   - flush=1: out_vld<=0 and dest<=0. Data outputs are don't-care but must be held. Flush wins over stall.
//   - stall=1, flush=0: every output holds its value. instr is not consumed; upstream must re-present it.
//     wb writes still update the register file during a stall.
//   - Otherwise: load the decoded values; out_vld<=instr_vld.
//   - When instr_vld=0, dest<=0 so no bubble ever targets a live register.
//  Simultaneous write and read of the same register: the new value is seen (bypass).
//   The bypass also covers the stall-release cycle, because the read is redone on release.
// TESTING
//  1. Reset: rst=1 for 1 cycle after random writes -> all R read 0, out_vld=0, outputs 0.
//  2. addi: wb R8=0x00000005, then instr addi $9,$8,-3 (0x2109FFFD)
//     -> next cycle op_a=5, op_b=0xFFFFFFFD, dest=9, out_vld=1.
//  3. Bypass: wb_we=1 wb_addr=8 wb_data=0x1234 in the same cycle as add $10,$8,$8
//     -> op_a=op_b=0x1234, dest=10.
//  4. $zero: wb_we=1 wb_addr=0 wb_data=0xFFFFFFFF, then or $1,$0,$0
//     -> op_a=op_b=0, dest=1.
//  5. ori zero-extend: ori $2,$0,0x8000 -> op_b=0x00008000; addi with the same imm -> op_b=0xFFFF8000.
//  6. Stall/flush: stall=1 for 3 cycles -> outputs frozen. stall=1 with flush=1 -> out_vld=0 next cycle.
//     Release -> the re-presented instruction loads.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Bus between the operand-fetch stage and its neighbours: the instruction in,
// write-back from downstream, and the ID/EX output register toward the ALU.
interface operand_fetch_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [31:0]   instr;
  logic          instr_vld;
  logic          stall;
  logic          flush;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] st_data;
  logic [AW-1:0] dest;
  logic          out_vld;

  // Valid/ready semantics: instr is consumed at a rising edge when instr_vld=1
  // and stall=0 (stall acts as a low ready); out_vld qualifies op_a/op_b/st_data/dest,
  // and a held instruction must be re-presented unchanged until stall drops.
  modport master (
    output instr, instr_vld, stall, flush, wb_we, wb_addr, wb_data,
    input  op_a, op_b, st_data, dest, out_vld
  );

  modport slave (
    input  instr, instr_vld, stall, flush, wb_we, wb_addr, wb_data,
    output op_a, op_b, st_data, dest, out_vld
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand stage: 32-entry register file with write-back bypass, immediate
// extension and the ID/EX output register feeding the ALU.
module operand_fetch #(
  parameter int DW    = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  operand_fetch_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  logic [DW-1:0] regs [NREGS];

  logic [5:0]    opcode;
  logic [AW-1:0] rs, rt, rd;
  logic [15:0]   imm;
  logic          wb_live;
  logic [DW-1:0] rs_val, rt_val, imm_ext;
  logic [DW-1:0] op_b_d;
  logic [AW-1:0] dest_d;
  logic          use_rt, zext;

  assign opcode = bus.instr[31:26];
  assign rs     = bus.instr[25:21];
  assign rt     = bus.instr[20:16];
  assign rd     = bus.instr[15:11];
  assign imm    = bus.instr[15:0];

  // R[0] is never written, so write-backs to it are dropped here and in the bypass.
  assign wb_live = bus.wb_we && (bus.wb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign rs_val = (rs == '0) ? '0 :
                  (wb_live && bus.wb_addr == rs) ? bus.wb_data : regs[rs];
  assign rt_val = (rt == '0) ? '0 :
                  (wb_live && bus.wb_addr == rt) ? bus.wb_data : regs[rt];

  always_comb begin
    use_rt  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE);
    zext    = (opcode == OP_ANDI) || (opcode == OP_ORI);
    imm_ext = zext ? {{(DW-16){1'b0}}, imm} : {{(DW-16){imm[15]}}, imm};
    op_b_d  = use_rt ? rt_val : imm_ext;
    // Bubbles carry dest=0 so downstream forwarding never matches a live register.
    dest_d  = '0;
    if (bus.instr_vld) dest_d = (opcode == OP_RTYPE) ? rd : rt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.op_a    <= '0;
      bus.op_b    <= '0;
      bus.st_data <= '0;
      bus.dest    <= '0;
      bus.out_vld <= 1'b0;
    end else if (bus.flush) begin
      bus.out_vld <= 1'b0;
      bus.dest    <= '0;
    end else if (!bus.stall) begin
      bus.op_a    <= rs_val;
      bus.op_b    <= op_b_d;
      bus.st_data <= rt_val;
      bus.dest    <= dest_d;
      bus.out_vld <= bus.instr_vld;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: each stimulus cycle queues the expected
// output register contents; a negedge monitor pops and compares them.
module tb_operand_fetch;
  localparam int W = 102;  // {out_vld, op_a, op_b, st_data, dest}

  logic clk = 1'b0;
  logic rst;

  operand_fetch_if #(.DW(32), .AW(5)) bus ();

  operand_fetch #(.DW(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, got, expv);
  endtask

  // Monitor: the output register is live every cycle, so every queued entry is checked.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk(nm, "out_vld", {31'd0, bus.out_vld}, {31'd0, e[101]});
      chk(nm, "op_a",    bus.op_a,              e[100:69]);
      chk(nm, "op_b",    bus.op_b,              e[68:37]);
      chk(nm, "st_data", bus.st_data,           e[36:5]);
      chk(nm, "dest",    {27'd0, bus.dest},     {27'd0, e[4:0]});
    end
  end

  task automatic step(input string nm, input logic r, input logic [31:0] ins,
                      input logic v, input logic st, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] es, input logic [4:0] ed);
    rst           = r;
    bus.instr     = ins;
    bus.instr_vld = v;
    bus.stall     = st;
    bus.flush     = fl;
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    @(posedge clk);
    exp_q.push_back({ev, ea, eb, es, ed});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add_a;
    step("reset0", 1, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("reset1", 1, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 5'd0);

    // Fill every register with random data, then reset with a write attempt pending.
    for (int r = 1; r < 32; r++)
      step("fill", 0, 32'h0, 0, 0, 0, 1, 5'(r), $urandom, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("rst_wb", 1, 32'h0, 0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 16; i++)
      step("rst_read", 0, rtype(5'(2*i), 5'(2*i+1), 5'(i+1), 6'h20), 1, 0, 0, 0, 5'd0, 32'h0,
           1, 32'h0, 32'h0, 32'h0, 5'(i+1));

    // addi $9,$8,-3 after R8=5
    step("wb_r8", 0, 32'h0, 0, 0, 0, 1, 5'd8, 32'h5, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("addi", 0, 32'h2109_FFFD, 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h5, 32'hFFFF_FFFD, 32'h0, 5'd9);

    // Same-cycle write-back bypass: add $10,$8,$8 while R8<=0x1234
    step("bypass", 0, rtype(5'd8, 5'd8, 5'd10, 6'h20), 1, 0, 0, 1, 5'd8, 32'h1234,
         1, 32'h1234, 32'h1234, 32'h1234, 5'd10);

    // Write to $zero is dropped
    step("wb_r0", 0, 32'h0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("or_zero", 0, rtype(5'd0, 5'd0, 5'd1, 6'h25), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h0, 32'h0, 32'h0, 5'd1);
    step("r0_byp", 0, rtype(5'd0, 5'd0, 5'd1, 6'h25), 1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF,
         1, 32'h0, 32'h0, 32'h0, 5'd1);

    // Immediate extension
    step("ori_zext", 0, itype(6'h0D, 5'd0, 5'd2, 16'h8000), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h0, 32'h0000_8000, 32'h0, 5'd2);
    step("addi_sext", 0, itype(6'h08, 5'd0, 5'd2, 16'h8000), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h0, 32'hFFFF_8000, 32'h0, 5'd2);
    step("andi_zext", 0, itype(6'h0C, 5'd8, 5'd3, 16'hFFFF), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h1234, 32'h0000_FFFF, 32'h0, 5'd3);
    step("lw_sext", 0, itype(6'h23, 5'd8, 5'd4, 16'hFFFC), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h1234, 32'hFFFF_FFFC, 32'h0, 5'd4);
    step("beq_rt", 0, itype(6'h04, 5'd8, 5'd8, 16'h0010), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h1234, 32'h1234, 32'h1234, 5'd8);
    step("bne_rt", 0, itype(6'h05, 5'd0, 5'd8, 16'h8000), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h0, 32'h1234, 32'h1234, 5'd8);

    // Stall: load addi $9,$8,1 then freeze for 3 cycles while R9 is written
    step("pre_stall", 0, itype(6'h08, 5'd8, 5'd9, 16'h0001), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h1234, 32'h1, 32'h0, 5'd9);
    for (int k = 0; k < 3; k++)
      step("stall", 0, rtype(5'd9, 5'd8, 5'd11, 6'h25), 1, 1, 0, (k == 1), 5'd9, 32'h77,
           1, 32'h1234, 32'h1, 32'h0, 5'd9);
    step("stall_flush", 0, rtype(5'd9, 5'd8, 5'd11, 6'h25), 1, 1, 1, 0, 5'd0, 32'h0,
         0, 32'h1234, 32'h1, 32'h0, 5'd0);
    // Release with a write-back to R8 that must be bypassed into the re-presented read
    step("release", 0, rtype(5'd9, 5'd8, 5'd11, 6'h25), 1, 0, 0, 1, 5'd8, 32'h55,
         1, 32'h77, 32'h55, 32'h55, 5'd11);
    step("bubble", 0, rtype(5'd8, 5'd8, 5'd12, 6'h20), 0, 0, 0, 0, 5'd0, 32'h0,
         0, 32'h55, 32'h55, 32'h55, 5'd0);
    step("flush_only", 0, rtype(5'd9, 5'd9, 5'd13, 6'h20), 1, 0, 1, 0, 5'd0, 32'h0,
         0, 32'h55, 32'h55, 32'h55, 5'd0);

    // Reset mid-stream discards the live instruction and clears the file
    add_a = 32'h77;
    step("live", 0, rtype(5'd9, 5'd8, 5'd14, 6'h20), 1, 0, 0, 0, 5'd0, 32'h0,
         1, add_a, 32'h55, 32'h55, 5'd14);
    step("mid_rst", 1, rtype(5'd9, 5'd8, 5'd14, 6'h20), 1, 0, 0, 0, 5'd0, 32'h0,
         0, 32'h0, 32'h0, 32'h0, 5'd0);
    step("post_rst", 0, rtype(5'd9, 5'd8, 5'd14, 6'h20), 1, 0, 0, 0, 5'd0, 32'h0,
         1, 32'h0, 32'h0, 32'h0, 5'd14);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
